// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the dmem_responder block: access-type codes, FSM
// state encoding and the misalignment predicate.
package dmem_responder_pkg;

  localparam logic [3:0] MEMC_LW  = 4'd0;
  localparam logic [3:0] MEMC_LH  = 4'd1;
  localparam logic [3:0] MEMC_LHU = 4'd2;
  localparam logic [3:0] MEMC_LB  = 4'd3;
  localparam logic [3:0] MEMC_LBU = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Undefined access codes behave as word accesses, so they align like words.
  function automatic logic is_misaligned(input logic [3:0] ctrl, input logic [1:0] offset);
    case (ctrl)
      MEMC_LH, MEMC_LHU: return offset[0];
      MEMC_LB, MEMC_LBU: return 1'b0;
      default:           return (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_lane.sv
// dmem_lane_unit: combinational byte-lane steering for stores (byte enables,
// replicated write data) and lane extraction with sign/zero extension for loads.
module dmem_lane_unit
  import dmem_responder_pkg::*;
(
  input  logic [3:0]  ctrl,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [15:0] half_s;
  logic [7:0]  byte_s;

  // Lane select and extension; word access ignores offset (forced alignment).
  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    rdata_ext  = rword;
    half_s     = 16'd0;
    byte_s     = 8'd0;
    case (ctrl)
      MEMC_LH, MEMC_LHU: begin
        if (offset[1]) begin
          be     = 4'b1100;
          half_s = rword[31:16];
        end else begin
          be     = 4'b0011;
          half_s = rword[15:0];
        end
        wdata_lane = {2{wdata[15:0]}};
        if (ctrl == MEMC_LH) begin
          rdata_ext = {{16{half_s[15]}}, half_s};
        end else begin
          rdata_ext = {16'd0, half_s};
        end
      end
      MEMC_LB, MEMC_LBU: begin
        be         = 4'b0001 << offset;
        byte_s     = rword[{offset, 3'b000} +: 8];
        wdata_lane = {4{wdata[7:0]}};
        if (ctrl == MEMC_LB) begin
          rdata_ext = {{24{byte_s[7]}}, byte_s};
        end else begin
          rdata_ext = {24'd0, byte_s};
        end
      end
      default: begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rword;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with valid/ready request and response.
// Optional macro DMEM_MISALIGN_TRAP_EN flags misaligned half/word accesses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_ctrl,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  state_e               state_r, state_nx;
  logic [CW-1:0]        cnt_r, cnt_nx;
  logic                 accept_s, commit_s;
  logic                 req_ready_r, resp_valid_r, resp_err_r;
  logic [31:0]          resp_rdata_r;

  logic                 we_r;
  logic [3:0]           ctrl_r;
  logic [AW+1:0]        addr_r;
  logic [31:0]          wdata_r;

  logic                 acc_we_s;
  logic [3:0]           acc_ctrl_s;
  logic [AW+1:0]        acc_addr_s;
  logic [31:0]          acc_wdata_s;
  logic [AW-1:0]        idx_s;
  logic                 err_s, write_en_s;
  logic [3:0]           be_s;
  logic [31:0]          wlane_s, rext_s, rword_s, merged_s;
  logic [DEPTH_WORDS-1:0][31:0] mem_s;
  logic                 unused_addr_s;

  assign unused_addr_s = ^req_addr[31:AW+2];

  // With zero wait states the access commits in IDLE straight from the inputs.
  assign acc_we_s    = (state_r == ST_IDLE) ? req_we              : we_r;
  assign acc_ctrl_s  = (state_r == ST_IDLE) ? req_ctrl            : ctrl_r;
  assign acc_addr_s  = (state_r == ST_IDLE) ? req_addr[AW+1:0]    : addr_r;
  assign acc_wdata_s = (state_r == ST_IDLE) ? req_wdata           : wdata_r;
  assign idx_s       = acc_addr_s[AW+1:2];
  assign rword_s     = mem_s[idx_s];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign err_s = is_misaligned(acc_ctrl_s, acc_addr_s[1:0]);
`else
  assign err_s = 1'b0;
`endif

  assign write_en_s = commit_s & acc_we_s & ~err_s;

  dmem_lane_unit u_lane (
    .ctrl       (acc_ctrl_s),
    .offset     (acc_addr_s[1:0]),
    .wdata      (acc_wdata_s),
    .rword      (rword_s),
    .be         (be_s),
    .wdata_lane (wlane_s),
    .rdata_ext  (rext_s)
  );

  // Merge the enabled lanes into the current word contents.
  always_comb begin
    merged_s = rword_s;
    for (int b = 0; b < 4; b++) begin
      if (be_s[b]) begin
        merged_s[8*b +: 8] = wlane_s[8*b +: 8];
      end else begin
        merged_s[8*b +: 8] = rword_s[8*b +: 8];
      end
    end
  end

  // FSM next-state, counter and accept/commit strobes.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    accept_s = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (WAIT_CYCLES == 0) begin
            commit_s = 1'b1;
            cnt_nx   = '0;
            state_nx = ST_RESP;
          end else begin
            cnt_nx   = CW'(WAIT_CYCLES);
            state_nx = ST_WAIT;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= CW'(1)) begin
          commit_s = 1'b1;
          cnt_nx   = '0;
          state_nx = ST_RESP;
        end else begin
          cnt_nx   = cnt_r - CW'(1);
          state_nx = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_RESP;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // State register with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nx;
      cnt_r        <= cnt_nx;
      req_ready_r  <= (state_nx == ST_IDLE);
      resp_valid_r <= (state_nx == ST_RESP);
    end
  end

  // Request latch and response data; stores and trapped accesses return 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r         <= 1'b0;
      ctrl_r       <= 4'd0;
      addr_r       <= '0;
      wdata_r      <= 32'd0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        we_r    <= req_we;
        ctrl_r  <= req_ctrl;
        addr_r  <= req_addr[AW+1:0];
        wdata_r <= req_wdata;
      end
      if (commit_s) begin
        resp_rdata_r <= (acc_we_s | err_s) ? 32'd0 : rext_s;
        resp_err_r   <= err_s;
      end
    end
  end

  for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_word
    logic [31:0] word_r;
    // One storage word, cleared by reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        word_r <= 32'd0;
      end else if (write_en_s && (idx_s == AW'(g))) begin
        word_r <= merged_s;
      end
    end
    assign mem_s[g] = word_r;
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-array
// reference model; honours DMEM_MISALIGN_TRAP_EN when defined.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_ctrl = 4'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int errors = 0;
  int checks = 0;
  logic [7:0] ref_b [DEPTH*4];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_ctrl   (req_ctrl),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH*4; i++) ref_b[i] = 8'h00;
  endfunction

  // Little-endian byte memory; access size/signedness from the access code.
  function automatic void model(input logic we, input logic [3:0] ctrl, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int size;
    bit sgn;
    int base;
    logic [31:0] v;
    case (ctrl)
      4'd1:    begin size = 2; sgn = 1'b1; end
      4'd2:    begin size = 2; sgn = 1'b0; end
      4'd3:    begin size = 1; sgn = 1'b1; end
      4'd4:    begin size = 1; sgn = 1'b0; end
      default: begin size = 4; sgn = 1'b0; end
    endcase
    er = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    er = ((int'(addr[1:0]) % size) != 0);
`endif
    base = (int'(addr[11:0]) / size) * size;
    rd = 32'd0;
    if (er) begin
      rd = 32'd0;
    end else if (we) begin
      for (int k = 0; k < size; k++) ref_b[base+k] = wd[8*k +: 8];
    end else begin
      v = 32'd0;
      for (int k = 0; k < size; k++) v[8*k +: 8] = ref_b[base+k];
      if (sgn && v[8*size-1]) begin
        for (int k = size; k < 4; k++) v[8*k +: 8] = 8'hFF;
      end
      rd = v;
    end
  endfunction

  task automatic do_req(input logic we, input logic [3:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, input bit poke,
                        output logic [31:0] got);
    logic [31:0] exp_d;
    logic        exp_e;
    int          lat;
    model(we, ctrl, addr, wdata, exp_d, exp_e);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_ctrl = ctrl; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!resp_valid) chk("req_ready_busy", 32'(req_ready), 32'd0);
    end while (!resp_valid && lat < 20);
    chk("latency", 32'(lat), 32'(WAITC + 1));
    got = resp_rdata;
    chk("rdata", resp_rdata, exp_d);
    chk("err", 32'(resp_err), 32'(exp_e));
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        req_valid = 1'b1; req_we = 1'b1; req_ctrl = 4'd0;
        req_addr = $urandom; req_wdata = $urandom;
      end
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_rdata", resp_rdata, exp_d);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("post_valid", 32'(resp_valid), 32'd0);
    chk("post_ready", 32'(req_ready), 32'd1);
    if (poke) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("poke_ignored", 32'(resp_valid), 32'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    logic [3:0]  c;
    int          r;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);

    do_req(1'b0, 4'd0, 32'h0, 32'h0, 0, 1'b0, got);
    chk("tp_lw0", got, 32'h0);
    do_req(1'b1, 4'd0, 32'h10, 32'hDEADBEEF, 0, 1'b0, got);
    do_req(1'b0, 4'd3, 32'h11, 32'h0, 0, 1'b0, got);
    chk("tp_lb", got, 32'hFFFFFFBE);
    do_req(1'b0, 4'd4, 32'h11, 32'h0, 1, 1'b0, got);
    chk("tp_lbu", got, 32'h000000BE);
    do_req(1'b0, 4'd1, 32'h12, 32'h0, 0, 1'b0, got);
    chk("tp_lh", got, 32'hFFFFDEAD);
    do_req(1'b0, 4'd2, 32'h12, 32'h0, 0, 1'b0, got);
    chk("tp_lhu", got, 32'h0000DEAD);
    do_req(1'b1, 4'd3, 32'h13, 32'hFFFFFF5A, 0, 1'b0, got);
    do_req(1'b0, 4'd0, 32'h10, 32'h0, 0, 1'b0, got);
    chk("tp_sb_lw", got, 32'h5AADBEEF);
    do_req(1'b1, 4'd1, 32'h10, 32'hAAAA1234, 0, 1'b0, got);
    do_req(1'b0, 4'd0, 32'h10, 32'h0, 5, 1'b1, got);
    chk("tp_sh_lw", got, 32'h5AAD1234);

    // Reset during WAIT of a store: the store is lost with the cleared memory.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_ctrl = 4'd0; req_addr = 32'h20; req_wdata = 32'h11111111;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk("midrst_valid", 32'(resp_valid), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_quiet", 32'(resp_valid), 32'd0);
    end
    do_req(1'b0, 4'd0, 32'h20, 32'h0, 0, 1'b0, got);
    chk("tp_midrst_lw", got, 32'h0);

    do_req(1'b1, 4'd0, 32'h22, 32'hCAFEF00D, 0, 1'b0, got);
    do_req(1'b0, 4'd0, 32'h20, 32'h0, 0, 1'b0, got);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("tp_misalign_lw", got, 32'h0);
`else
    chk("tp_misalign_lw", got, 32'hCAFEF00D);
`endif

    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 6);
      c = (r > 4) ? 4'(r + 8) : 4'(r);
      a = $urandom & 32'hFFFF_F03F;
      do_req(1'($urandom_range(0, 1)), c, a, $urandom, $urandom_range(0, 2),
             1'($urandom_range(0, 3) == 0), got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
